mont_mul_serial: RTL and testbench
==================================

# mont_mul_serial

Bit-serial radix-2 Montgomery multiplier computing result = a·b·2^-N mod m. It is the arithmetic core directly downstream of the RSA command wrapper, and is instantiated by the wrapper and by the exponentiation controller. Operands are latched on a single-cycle start. The core scans one bit of a per clock, then applies a final conditional subtraction and pulses done.

## Interface
Parameters:
- N, 1024, operand width in bits (N ≥ 4)

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  start request; sampled only in IDLE
- in_a  in  N  multiplier operand a (scanned LSB first)
- in_b  in  N  multiplicand operand b
- in_m  in  N  modulus m
- busy  out  1  high from the cycle after start is accepted through the cycle done is high
- done  out  1  single-cycle pulse; result is valid from this cycle onward
- result  out  N  Montgomery product; held until the next accepted start

## Operation
- Preconditions (caller's responsibility):
  - m odd
  - m < 2^(N-1)
  - a < m and b < m
- If a precondition is violated, the result is undefined. Latency and handshake are unchanged.
- States and transitions:
  - IDLE → ITER on start=1. On that edge: A←in_a, B←in_b, M←in_m, C←0, cnt←0.
  - ITER: one iteration per cycle.
    - t = C + a_cnt·B
    - q = t[0]
    - C ← (t + q·M) >> 1
    - cnt ← cnt+1
    - After the iteration with cnt = N-1, go to SUB.
  - SUB: result ← (C ≥ M) ? C−M : C. Go to DONE.
  - DONE: done=1, busy=1. Go to IDLE.
- Width rules:
  - C and intermediate sums are N+2 bits wide and never overflow under the preconditions.
  - C < 2M holds throughout.
  - result is the low N bits after SUB.
- Start while not in IDLE (including the DONE cycle): ignored, no queueing.
- Start in IDLE with operands changing afterwards: no effect, because operands were latched at acceptance.
- Reset at any point, including mid-ITER:
  - next state IDLE
  - busy=0, done=0, result=0, cnt=0
  - no partial result is retained

## Timing
- Reset values: busy=0, done=0, result=0.
- Start accepted at edge E0:
  - busy=1 from E0.
  - ITER occupies N cycles.
  - SUB occupies 1 cycle.
  - done is high during the cycle after edge E0+N+1.
  - Latency from acceptance to done is N+2 cycles (N+1 with the macro off).
- done is high for exactly 1 cycle. busy falls together with done.
- The earliest next start is accepted in the first IDLE cycle after done, so back-to-back throughput is one product per N+3 cycles.
- result changes only at the SUB edge.

## Configuration
- MONT_MUL_FINAL_SUB_EN defined (default build):
  - SUB state present
  - result < m
  - latency N+2
- Not defined:
  - SUB state removed; ITER goes directly to DONE
  - result = C, in the range [0, 2m)
  - latency N+1
  - intended for exponentiation chains that reduce only at the end
  - the bench expectation must accept either r or r+m

## Structure
- Shared package mont_pkg holds:
  - state encoding localparams (IDLE, ITER, SUB, DONE), STATE_BITS = 2
  - default N = 1024
  - counter width: $clog2(N)
- Sub-module mont_mul_step: purely combinational single iteration. Inputs C, B, M, a_bit; output next C, N+2 bits wide. This isolates the critical adder path for later CSA replacement.
- The top level holds the FSM, counter, operand registers and output register.

## Test plan
- N=8, m=13, a=5, b=7, start pulse → done at cycle 10 after acceptance, result=1. With the macro off: done at cycle 9, result 1 or 14.
- N=8, m=13, a=1, b=3 (R² mod m) → result=9 (R mod m). Then a=b=12 → result=3. Run back-to-back, with start asserted on the first IDLE cycle after done.
- N=8, a=0, b=12, m=13 → result=0. busy high for exactly 10 cycles.
- Start re-pulsed at iterations 2 and 5 with different operands → ignored; result still matches the first operands; single done pulse.
- N=1024, resetn low during iteration 500 → next cycle busy=0, done=0, result=0. A fresh start with random a, b < m (m odd, top bit clear) matches the reference model after 1026 cycles.
- N=1024: 1000 random operand sets checked against a software model of a·b·2^-1024 mod m; start is never accepted while busy.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier.
package mont_pkg;

  localparam int unsigned N_DEFAULT  = 1024;
  localparam int unsigned STATE_BITS = 2;

  typedef enum logic [STATE_BITS-1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Width of the iteration counter for an n-bit operand.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mont_mul_step.sv
// One radix-2 Montgomery iteration: C' = (C + a_bit*B + q*M) >> 1.
// Kept separate so the adder chain can later be swapped for a CSA form.
module mont_mul_step #(
  parameter int unsigned N = 1024
) (
  input  logic [N+1:0] i_c,
  input  logic [N-1:0] i_b,
  input  logic [N-1:0] i_m,
  input  logic         i_a_bit,
  output logic [N+1:0] o_c
);

  logic [N+1:0] w_t;
  logic [N+1:0] w_u;

  // Add the selected multiplicand, then make the sum even with M and halve.
  // C < 2M, B < M and M < 2^(N-1) keep every sum below 2^(N+1).
  always_comb begin
    w_t = i_c + (i_a_bit ? {2'b00, i_b} : '0);
    w_u = w_t + (w_t[0] ? {2'b00, i_m} : '0);
    o_c = w_u >> 1;
  end

endmodule

// File: rtl/mont_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-N mod m.
// Build option MONT_MUL_FINAL_SUB_EN: when defined, a final conditional
// subtraction state gives result < m; when undefined the raw C in [0, 2m)
// is returned one cycle earlier.
module mont_mul_serial
  import mont_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned CW = cnt_width(N);

  state_t         r_state;
  state_t         w_next_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_m;
  logic [N+1:0]   r_c;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_result;
  logic           r_busy;
  logic           r_done;
  logic [N+1:0]   w_c_next;
  logic           w_last;
`ifdef MONT_MUL_FINAL_SUB_EN
  logic [N+1:0]   w_diff;
`endif

  mont_mul_step #(.N(N)) u_step (
    .i_c     (r_c),
    .i_b     (r_b),
    .i_m     (r_m),
    .i_a_bit (r_a[0]),
    .o_c     (w_c_next)
  );

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_last       = (r_cnt == CW'(N - 1));
`ifdef MONT_MUL_FINAL_SUB_EN
    w_diff       = r_c - {2'b00, r_m};
`endif
    case (r_state)
      S_IDLE: if (start) w_next_state = S_ITER;
`ifdef MONT_MUL_FINAL_SUB_EN
      S_ITER: if (w_last) w_next_state = S_SUB;
      S_SUB:  w_next_state = S_DONE;
`else
      S_ITER: if (w_last) w_next_state = S_DONE;
`endif
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs; a is shifted so bit 0 is the
  // current scan bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_c      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_next_state != S_IDLE);
      r_done <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_m   <= in_m;
            r_c   <= '0;
            r_cnt <= '0;
          end
        end
        S_ITER: begin
          r_c   <= w_c_next;
          r_a   <= r_a >> 1;
          r_cnt <= r_cnt + CW'(1);
`ifndef MONT_MUL_FINAL_SUB_EN
          if (w_last) r_result <= w_c_next[N-1:0];
`endif
        end
`ifdef MONT_MUL_FINAL_SUB_EN
        S_SUB: begin
          r_result <= (r_c >= {2'b00, r_m}) ? w_diff[N-1:0] : r_c[N-1:0];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_serial.sv
// Self-checking bench for mont_mul_serial at N=8 with a result scoreboard.
module tb_mont_mul_serial;

  localparam int unsigned TN = 8;
`ifdef MONT_MUL_FINAL_SUB_EN
  localparam int unsigned LAT = TN + 2;
`else
  localparam int unsigned LAT = TN + 1;
`endif

  typedef struct {
    logic [TN-1:0] r;
    logic [TN-1:0] m;
    int unsigned   t0;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [TN-1:0] in_a;
  logic [TN-1:0] in_b;
  logic [TN-1:0] in_m;
  logic          busy;
  logic          done;
  logic [TN-1:0] result;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  logic        prev_done = 1'b0;
  exp_t        sb[$];

  mont_mul_serial #(.N(TN)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_m   (in_m),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: brute-force r in [0,m) with r*2^TN == a*b (mod m).
  function automatic logic [TN-1:0] ref_mont(input int a, input int b, input int m);
    for (int r = 0; r < m; r++)
      if (((r * (1 << TN)) % m) == ((a * b) % m)) return TN'(r);
    return '0;
  endfunction

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (resetn && done) begin
      chk("done_single", 32'(prev_done), 32'd0);
      chk("busy_at_done", 32'(busy), 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        logic [TN-1:0] want;
        e = sb.pop_front();
        want = e.r;
`ifndef MONT_MUL_FINAL_SUB_EN
        if (result == TN'(e.r + e.m)) want = TN'(e.r + e.m);
`endif
        chk("result", 32'(result), 32'(want));
        chk("latency", cyc - e.t0, LAT);
      end
    end
    prev_done = resetn ? done : 1'b0;
  end

  // Wait for IDLE, then pulse start for one cycle; operands are scrambled after.
  task automatic start_op(input logic [TN-1:0] a, input logic [TN-1:0] b,
                          input logic [TN-1:0] m, input logic [TN-1:0] r);
    int unsigned n = 0;
    exp_t e;
    @(negedge clk);
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) chk("timeout_idle", 32'd1, 32'd0);
    in_a = a; in_b = b; in_m = m; start = 1'b1;
    e.r = r; e.m = m; e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    in_a = TN'($urandom); in_b = TN'($urandom); in_m = TN'($urandom);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((sb.size() != 0 || busy) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) chk("timeout_drain", 32'd1, 32'd0);
  endtask

  initial begin
    int unsigned bc;
    resetn = 1'b0; start = 1'b0; in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    resetn = 1'b1;

    // Directed products, issued back-to-back.
    start_op(8'd5, 8'd7, 8'd13, 8'd1);
    start_op(8'd1, 8'd3, 8'd13, 8'd9);
    start_op(8'd12, 8'd12, 8'd13, 8'd3);
    drain();

    // Zero operand and busy width.
    start_op(8'd0, 8'd12, 8'd13, 8'd0);
    bc = 1;
    while (busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    chk("busy_cycles", bc - 1, LAT);
    drain();

    // Start re-pulsed mid-iteration with other operands is ignored.
    start_op(8'd5, 8'd7, 8'd13, 8'd1);
    @(negedge clk);
    in_a = 8'd9; in_b = 8'd4; in_m = 8'd11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    in_a = 8'd3; in_b = 8'd2; in_m = 8'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("no_extra_done", 32'(busy), 32'd0);

    // Reset mid-iteration discards the operation.
    start_op(8'd12, 8'd11, 8'd13, 8'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    resetn = 1'b1;
    start_op(8'd12, 8'd11, 8'd13, ref_mont(12, 11, 13));
    drain();

    // Random operands: m odd below 2^(TN-1), a and b below m.
    for (int i = 0; i < 300; i++) begin
      int m, a, b;
      m = 2 * int'($urandom_range(1, 63)) + 1;
      a = int'($urandom_range(0, m - 1));
      b = int'($urandom_range(0, m - 1));
      start_op(TN'(a), TN'(b), TN'(m), ref_mont(a, b, m));
    end
    drain();
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
